// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states and
// the fixed quotient returned on divide-by-zero.
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_MUL  = 2'd1;
  localparam mdu_state_t ST_DIV  = 2'd2;
  localparam mdu_state_t ST_FIX  = 2'd3;

  // Sliced down to WIDTH by the user; covers operand widths up to 128.
  localparam int MDU_MAX_WIDTH = 128;
  localparam logic [MDU_MAX_WIDTH-1:0] MDU_DIV0_Q = '1;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// Handshake: a request is taken on the rising edge where start=1, cancel=0 and
// busy=0; while stall=1 the requester holds start/op/a/b steady. done is a
// one-cycle pulse marking new hi/lo; cancel aborts whatever is in flight.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, stall, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// WIDTH steps after a load. last flags the step that completes the quotient.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  // quo starts as the dividend and is shifted out into the partial remainder.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (load) begin
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= '0;
    end else if (step) begin
      if (diff[WIDTH]) begin
        rem <= rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end
      count <= count + 1'b1;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign last      = (count == CW'(WIDTH - 1));
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo} for the HILO
// registers, with pipeline-flush cancel and defined divide corner cases.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus,
  output logic [1:0]   fsm_state
);
  localparam int W   = WIDTH;
  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  mdu_state_t       state;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     hi_q, lo_q;
  logic [MCW-1:0]   mul_cnt;
  logic             done_q;
  logic             accept;
  logic [W-1:0]     a_mag, b_mag;
  logic [W-1:0]     div_q, div_r;
  logic             div_last;
  logic [2*W-1:0]   mul_a, mul_b, product;
  logic [W-1:0]     fix_q, fix_r;

  assign accept = (state == ST_IDLE) && bus.start && !bus.cancel;

  // The divider sees magnitudes; signs are restored in FIX from the latched operands.
  assign a_mag = (bus.op == MDU_DIV && bus.a[W-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.op == MDU_DIV && bus.b[W-1]) ? -bus.b : bus.b;

  muldiv_div_core #(.WIDTH(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && bus.op[1]),
    .step      (state == ST_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  // Extending to 2W bits first makes the low 2W bits of one unsigned multiply correct for both signednesses.
  assign mul_a   = (op_q == MDU_MULT) ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign mul_b   = (op_q == MDU_MULT) ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
  assign product = mul_a * mul_b;

  always_comb begin
    fix_q = div_q;
    fix_r = div_r;
    if (op_q == MDU_DIV) begin
      if (a_q[W-1] ^ b_q[W-1]) fix_q = -div_q;
      if (a_q[W-1])            fix_r = -div_r;
    end
    if (b_q == '0) begin
      fix_q = MDU_DIV0_Q[W-1:0];
      fix_r = a_q;
    end else if (op_q == MDU_DIV && a_q == {1'b1, {(W-1){1'b0}}} && b_q == '1) begin
      fix_q = {1'b1, {(W-1){1'b0}}};
      fix_r = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mul_cnt <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            mul_cnt <= '0;
            state   <= bus.op[1] ? ST_DIV : ST_MUL;
          end
          ST_MUL: if (mul_cnt == MCW'(MUL_STAGES - 1)) begin
            hi_q   <= product[2*W-1:W];
            lo_q   <= product[W-1:0];
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
          ST_DIV: if (div_last) state <= ST_FIX;
          ST_FIX: begin
            hi_q   <= fix_r;
            lo_q   <= fix_q;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.stall = (bus.start & ~bus.cancel) | bus.busy;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign fsm_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32, MUL_STAGES=2 with an arithmetic
// reference model, an expected-result queue and per-cycle hold checking.
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fsm_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [63:0] exp_q[$];
  logic [31:0] held_hi = '0;
  logic [31:0] held_lo = '0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint             p;
    logic signed [31:0] sx, sy, sq, sr;
    logic [31:0]        uq, ur;
    case (o)
      MDU_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
      end
      MDU_MULTU: return {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == MDU_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (o == MDU_DIV) begin
          sx = x; sy = y;
          sq = sx / sy;
          sr = sx % sy;
          return {sr, sq};
        end
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
    endcase
  endfunction

  // scoreboard: results on done, hold everywhere else
  always @(negedge clk) begin : compare
    logic [63:0] e;
    if (rst) begin
      held_hi = '0;
      held_lo = '0;
      exp_q.delete();
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {bus.hi, bus.lo}, e);
        held_hi = e[63:32];
        held_lo = e[31:0];
      end
    end else begin
      check("hold", {bus.hi, bus.lo}, {held_hi, held_lo});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int got);
    got = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        got = cyc;
        break;
      end
      tick();
    end
  endtask

  // drives start in the current cycle; returns in the done cycle
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] lit, input int lat, input string name);
    int          n, got;
    logic [63:0] e;
    e = model(o, x, y);
    check({name, "_model"}, e, lit);
    n = cyc;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    exp_q.push_back(e);
    #1 check({name, "_stall"}, 64'(bus.stall), 64'd1);
    tick();
    bus.start = 1'b0;
    check({name, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(got);
    check({name, "_latency"}, 64'(got - n), 64'(lat));
    check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({name, "_hilo"}, {bus.hi, bus.lo}, lit);
  endtask

  // starts an op now and raises cancel k cycles later; no result is expected
  task automatic cancel_at(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int k, input string name);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    tick();
    bus.start = 1'b0;
    repeat (k - 1) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin : stimulus
    int n, got, seen;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_hilo",  {bus.hi, bus.lo}, 64'd0);
    check("reset_busy",  64'(bus.busy), 64'd0);
    check("reset_done",  64'(bus.done), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(ST_IDLE));
    tick();

    do_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3,          64'hFFFF_FFFF_FFFF_FFFA, 3,  "mult_neg");
    tick();
    do_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3,          64'h0000_0002_FFFF_FFFA, 3,  "multu");
    tick();
    do_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000, 3,  "mult_min");
    tick();
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 3,  "multu_max");
    tick();
    do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 34, "div_neg");
    tick();
    do_op(MDU_DIVU,  32'd7,         32'd2,          64'h0000_0001_0000_0003, 34, "divu");
    tick();
    do_op(MDU_DIV,   32'h1234_5678, 32'd0,          64'h1234_5678_FFFF_FFFF, 34, "div_zero");
    tick();
    do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 34, "div_ovf");
    tick();
    do_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 34, "div_pos_neg");
    do_op(MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE,  64'hFFFF_FFFF_0000_0003, 34, "div_neg_neg");
    tick();
    do_op(MDU_DIVU,  32'hFFFF_FFF9, 32'd2,          64'h0000_0001_7FFF_FFFC, 34, "divu_big");
    tick();
    do_op(MDU_DIVU,  32'd5,         32'd0,          64'h0000_0005_FFFF_FFFF, 34, "divu_zero");
    tick();
    do_op(MDU_DIVU,  32'd0,         32'd5,          64'h0000_0000_0000_0000, 34, "divu_zero_dividend");
    tick();

    // DIVU 100/7 cancelled at N+10, MULTU 5x6 started at N+11
    n = cyc;
    cancel_at(MDU_DIVU, 32'd100, 32'd7, 10, "cancel_div");
    check("cancel_restart_cycle", 64'(cyc - n), 64'd11);
    do_op(MDU_MULTU, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 3, "after_cancel");
    tick();

    // cancel in the completion cycle of MUL (N+2) and of FIX (N+33)
    cancel_at(MDU_MULT, 32'd2, 32'd3, 2, "cancel_mul_last");
    tick();
    cancel_at(MDU_DIV, 32'd9, 32'd2, 33, "cancel_fix");
    tick();

    // cancel together with start in IDLE
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd3; bus.b = 32'd3;
    #1 check("start_cancel_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("start_cancel_busy", 64'(bus.busy), 64'd0);
    repeat (5) tick();

    // back-to-back: start held through the first done cycle
    n = cyc;
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd3; bus.b = 32'hFFFF_FFFB;
    exp_q.push_back(model(MDU_MULT, 32'd3, 32'hFFFF_FFFB));
    tick();
    bus.op = MDU_MULTU; bus.a = 32'h0001_0000; bus.b = 32'h0001_0000;
    exp_q.push_back(model(MDU_MULTU, 32'h0001_0000, 32'h0001_0000));
    wait_done(got);
    check("b2b_first_latency", 64'(got - n), 64'd3);
    check("b2b_first_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("b2b_stall_at_done", 64'(bus.stall), 64'd1);
    tick();
    bus.start = 1'b0;
    check("b2b_accepted", 64'(bus.busy), 64'd1);
    wait_done(got);
    check("b2b_second_latency", 64'(got - n), 64'd6);
    check("b2b_second_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    tick();

    // reset at N+5 of a DIV
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
